lcd_screen_arbiter: RTL and testbench

// Shares the single 2x16 character LCD among NREQ message sources (alarm, brew status, menu, idle banner, ...).

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_prio_enc.sv | 25 ++
 rtl/lcd_screen_arbiter.sv | 138 +++++++++++++
 tb/tb_lcd_screen_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: row geometry, arbiter state encoding and 50 MHz timing constants
// used by both the screen arbiter and the LCD driver.
package lcd_pkg;

    localparam int LCD_ROW_W = 128;
    localparam int LCD_CHARS = 16;
    localparam int IDX_W     = 3;

    localparam logic [LCD_ROW_W-1:0] BLANK_ROW = {LCD_CHARS{8'h20}};

    // Cycle counts at 50 MHz; the driver uses the HD44780 delays.
    localparam int CLK_HZ        = 50_000_000;
    localparam int HOLD_500MS    = CLK_HZ / 2;
    localparam int LCD_PWRUP_CYC = (CLK_HZ / 1000) * 15;
    localparam int LCD_CMD_CYC   = (CLK_HZ / 1_000_000) * 40;
    localparam int LCD_CLR_CYC   = (CLK_HZ / 1_000_000) * 1640;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_HOLD  = 2'd1,
        S_OPEN  = 2'd2
    } arb_state_e;

    function automatic logic [LCD_ROW_W-1:0] fill_row(input logic [7:0] ch);
        return {LCD_CHARS{ch}};
    endfunction

endpackage

// File: rtl/lcd_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins, returned both as index and one-hot.
module lcd_prio_enc
    import lcd_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]  req,
    output logic             req_any,
    output logic [IDX_W-1:0] win_idx,
    output logic [NREQ-1:0]  win_onehot
);

    assign req_any    = |req;
    assign win_onehot = req & (~req + NREQ'(1));

    always_comb begin
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lcd_screen_arbiter.sv
// Shares the 2x16 LCD among NREQ message sources with fixed priority (index 0 highest)
// and a minimum hold time so a freshly shown message stays readable.
module lcd_screen_arbiter
    import lcd_pkg::*;
#(
    parameter int         NREQ     = 3,
    parameter int         MIN_HOLD = 25_000_000,
    parameter int         HOLD_W   = 25,
    parameter logic [7:0] BLANK    = 8'h20
) (
    input  logic                      CLOCK,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*LCD_ROW_W-1:0] src_row1,
    input  logic [NREQ*LCD_ROW_W-1:0] src_row2,
    output logic [NREQ-1:0]           grant,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [NREQ-1:0]           shown,
    output logic                      hold_busy,
    output logic [LCD_ROW_W-1:0]      row_1,
    output logic [LCD_ROW_W-1:0]      row_2
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD  = (MIN_HOLD == 0) ? '0 : HOLD_W'(MIN_HOLD - 1);
    localparam arb_state_e        TAKE_STATE = (MIN_HOLD == 0) ? S_OPEN : S_HOLD;

    arb_state_e           state, state_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
    logic [NREQ-1:0]      grant_nxt, shown_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic [LCD_ROW_W-1:0] row1_nxt, row2_nxt;

    logic                 any_req, hp_any, owner_req, take;
    logic [IDX_W-1:0]     win_idx, hp_idx, take_idx;
    logic [NREQ-1:0]      win_oh, hp_oh, take_oh, hp_req;

    // grant is one-hot, so grant-1 masks exactly the sources above the owner in priority.
    assign hp_req    = req & (grant - NREQ'(1));
    assign owner_req = |(req & grant);
    assign hold_busy = (state == S_HOLD);

    lcd_prio_enc #(.NREQ(NREQ)) u_win_enc (
        .req        (req),
        .req_any    (any_req),
        .win_idx    (win_idx),
        .win_onehot (win_oh)
    );

    lcd_prio_enc #(.NREQ(NREQ)) u_hp_enc (
        .req        (hp_req),
        .req_any    (hp_any),
        .win_idx    (hp_idx),
        .win_onehot (hp_oh)
    );

    assign take_oh  = hp_any ? hp_oh  : win_oh;
    assign take_idx = hp_any ? hp_idx : win_idx;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        grant_nxt = grant;
        idx_nxt   = grant_idx;
        shown_nxt = '0;
        take      = 1'b0;

        case (state)
            S_BLANK: begin
                take = any_req;
            end
            S_HOLD: begin
                if (hp_any) begin
                    take = 1'b1;
                end else if (hold_cnt == '0) begin
                    state_nxt = S_OPEN;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            S_OPEN: begin
                if (!owner_req && !any_req) begin
                    state_nxt = S_BLANK;
                    grant_nxt = '0;
                    idx_nxt   = '0;
                end else if (!owner_req || hp_any) begin
                    take = 1'b1;
                end
            end
            default: begin
                state_nxt = S_BLANK;
                hold_nxt  = '0;
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        endcase

        if (take) begin
            state_nxt = TAKE_STATE;
            hold_nxt  = HOLD_LOAD;
            grant_nxt = take_oh;
            idx_nxt   = take_idx;
            shown_nxt = take_oh;
        end
    end

    // Text follows the next owner so grant and rows move on the same edge.
    always_comb begin
        row1_nxt = fill_row(BLANK);
        row2_nxt = fill_row(BLANK);
        for (int i = 0; i < NREQ; i++) begin
            if (grant_nxt[i]) begin
                row1_nxt = src_row1[i*LCD_ROW_W +: LCD_ROW_W];
                row2_nxt = src_row2[i*LCD_ROW_W +: LCD_ROW_W];
            end
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state     <= S_BLANK;
            hold_cnt  <= '0;
            grant     <= '0;
            grant_idx <= '0;
            shown     <= '0;
            row_1     <= fill_row(BLANK);
            row_2     <= fill_row(BLANK);
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            shown     <= shown_nxt;
            row_1     <= row1_nxt;
            row_2     <= row2_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_screen_arbiter.sv
// Self-checking bench for lcd_screen_arbiter: an owner/countdown model checked every cycle
// plus literal expectations for the directed scenarios.
module tb_lcd_screen_arbiter;

    localparam int NREQ     = 3;
    localparam int MIN_HOLD = 8;
    localparam int HOLD_W   = 4;
    localparam logic [127:0] BLANK_TXT = {16{8'h20}};

    logic                 CLOCK = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [127:0]         s1 [NREQ];
    logic [127:0]         s2 [NREQ];
    logic [NREQ*128-1:0]  src_row1, src_row2;
    logic [NREQ-1:0]      grant, shown;
    logic [2:0]           grant_idx;
    logic                 hold_busy;
    logic [127:0]         row_1, row_2;

    int passed = 0;
    int total  = 0;
    bit check_en = 1'b0;

    assign src_row1 = {s1[2], s1[1], s1[0]};
    assign src_row2 = {s2[2], s2[1], s2[0]};

    always #5 CLOCK = ~CLOCK;

    lcd_screen_arbiter #(
        .NREQ(NREQ), .MIN_HOLD(MIN_HOLD), .HOLD_W(HOLD_W), .BLANK(8'h20)
    ) dut (
        .CLOCK(CLOCK), .rst(rst), .req(req), .src_row1(src_row1), .src_row2(src_row2),
        .grant(grant), .grant_idx(grant_idx), .shown(shown), .hold_busy(hold_busy),
        .row_1(row_1), .row_2(row_2)
    );

    // Model: owner (-1 = blank) and cycles of hold remaining (0 = screen open).
    int           m_owner, m_hold, nx_owner, nx_hold, w;
    logic [2:0]   m_shown, nx_shown;
    logic [127:0] m_row1, m_row2, nx_row1, nx_row2;

    always_comb begin
        w = -1;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) w = i;
        end
        nx_owner = m_owner;
        nx_hold  = m_hold;
        if (m_owner < 0) begin
            if (w >= 0) begin nx_owner = w; nx_hold = MIN_HOLD; end
        end else if (w >= 0 && w < m_owner) begin
            nx_owner = w; nx_hold = MIN_HOLD;
        end else if (m_hold > 0) begin
            nx_hold = m_hold - 1;
        end else if (!req[m_owner]) begin
            if (w >= 0) begin nx_owner = w; nx_hold = MIN_HOLD; end
            else nx_owner = -1;
        end
        nx_shown = '0;
        if (nx_owner >= 0 && nx_owner != m_owner) nx_shown[nx_owner] = 1'b1;
        nx_row1 = (nx_owner >= 0) ? s1[nx_owner] : BLANK_TXT;
        nx_row2 = (nx_owner >= 0) ? s2[nx_owner] : BLANK_TXT;
    end

    always @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_hold  <= 0;
            m_shown <= '0;
            m_row1  <= BLANK_TXT;
            m_row2  <= BLANK_TXT;
        end else begin
            m_owner <= nx_owner;
            m_hold  <= nx_hold;
            m_shown <= nx_shown;
            m_row1  <= nx_row1;
            m_row2  <= nx_row2;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    always @(negedge CLOCK) begin
        if (check_en) begin
            checkOutput("m_grant", grant, (m_owner >= 0) ? (128'd1 << m_owner) : 128'd0);
            checkOutput("m_grant_idx", grant_idx, (m_owner >= 0) ? 128'(m_owner) : 128'd0);
            checkOutput("m_shown", shown, m_shown);
            checkOutput("m_hold_busy", hold_busy, (m_owner >= 0 && m_hold > 0) ? 128'd1 : 128'd0);
            checkOutput("m_row_1", row_1, m_row1);
            checkOutput("m_row_2", row_2, m_row2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #2;
    endtask

    task automatic applyStimulus(input logic [2:0] r);
        req = r;
    endtask

    task automatic countHold(output int n);
        n = 0;
        while (hold_busy && n < 20) begin
            n++;
            tick(1);
        end
    endtask

    int hold_len;

    initial begin
        rst   = 1'b1;
        req   = '0;
        s1[0] = {"ALARM NO WATER", {2{8'h20}}};
        s2[0] = {"REFILL TANK", {5{8'h20}}};
        s1[1] = {"BREWING", {9{8'h20}}};
        s2[1] = {"COUNTDOWN", {6{8'h20}}, "C"};
        s1[2] = {"READY", {11{8'h20}}};
        s2[2] = {"SELECT DRINK", {4{8'h20}}};
        tick(1);
        check_en = 1'b1;
        tick(1);
        checkOutput("reset_row_1", row_1, BLANK_TXT);
        checkOutput("reset_grant", grant, 3'b000);
        checkOutput("reset_hold_busy", hold_busy, 1'b0);
        rst = 1'b0;
        tick(2);

        $display("[TB] first grant from blank");
        applyStimulus(3'b100);
        tick(1);
        checkOutput("first_grant", grant, 3'b100);
        checkOutput("first_shown", shown, 3'b100);
        checkOutput("first_row_1", row_1, {"READY", {11{8'h20}}});
        countHold(hold_len);
        checkOutput("first_hold_len", hold_len, 8);

        $display("[TB] owner drops during hold");
        applyStimulus(3'b000);
        tick(1);
        applyStimulus(3'b100);
        tick(3);
        applyStimulus(3'b000);
        tick(5);
        checkOutput("drop_hold_kept", grant, 3'b100);
        checkOutput("drop_hold_busy", hold_busy, 1'b1);
        tick(1);
        checkOutput("drop_open_busy", hold_busy, 1'b0);
        checkOutput("drop_open_grant", grant, 3'b100);
        tick(1);
        checkOutput("drop_blank_grant", grant, 3'b000);
        checkOutput("drop_blank_row_1", row_1, BLANK_TXT);

        $display("[TB] preemption during hold");
        applyStimulus(3'b010);
        tick(3);
        applyStimulus(3'b011);
        tick(1);
        checkOutput("preempt_grant", grant, 3'b001);
        checkOutput("preempt_shown", shown, 3'b001);
        checkOutput("preempt_row_2", row_2, {"REFILL TANK", {5{8'h20}}});
        countHold(hold_len);
        checkOutput("preempt_hold_len", hold_len, 8);

        $display("[TB] owner drop in open picks lowest index");
        applyStimulus(3'b110);
        tick(1);
        checkOutput("open_drop_grant", grant, 3'b010);
        checkOutput("open_drop_busy", hold_busy, 1'b1);

        $display("[TB] live text update");
        checkOutput("live_before", row_2[7:0], 8'h43);
        s2[1][7:0] = "D";
        tick(1);
        checkOutput("live_after", row_2[7:0], 8'h44);

        $display("[TB] preemption on the last hold cycle");
        applyStimulus(3'b000);
        tick(12);
        checkOutput("idle_grant", grant, 3'b000);
        applyStimulus(3'b100);
        tick(8);
        applyStimulus(3'b110);
        tick(1);
        checkOutput("last_cycle_grant", grant, 3'b010);
        checkOutput("last_cycle_busy", hold_busy, 1'b1);
        tick(12);
        checkOutput("low_prio_waits", grant, 3'b010);
        applyStimulus(3'b001);
        tick(1);
        checkOutput("drop_with_hp", grant, 3'b001);

        $display("[TB] asynchronous reset mid-hold");
        tick(2);
        rst = 1'b1;
        #1;
        checkOutput("async_grant", grant, 3'b000);
        checkOutput("async_idx", grant_idx, 3'd0);
        checkOutput("async_busy", hold_busy, 1'b0);
        checkOutput("async_row_1", row_1, BLANK_TXT);
        checkOutput("async_row_2", row_2, BLANK_TXT);
        tick(2);
        rst = 1'b0;
        tick(3);
        checkOutput("after_reset_grant", grant, 3'b001);

        @(posedge CLOCK);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
